// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, the phase-accumulator
// sizing and increment laws (common to the RX and TX tick generators) and
// a 3-input majority helper used by the sample voter.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } rx_state_t;

    // Accumulator width: clog2(clk_freq/baud) + 8 fractional guard bits.
    function automatic int calc_acc_w(input longint unsigned clk_freq,
                                      input longint unsigned baud);
        longint unsigned ratio;
        int w;
        ratio = clk_freq / baud;
        w = 0;
        for (int i = 0; i < 63; i++) begin
            if ((64'd1 << i) < ratio) begin
                w = i + 1;
            end
        end
        return w + 8;
    endfunction

    // Increment = round(baud * os * 2^acc_w / clk_freq), all in 64 bits.
    function automatic longint unsigned calc_inc(input longint unsigned clk_freq,
                                                 input longint unsigned baud,
                                                 input longint unsigned os,
                                                 input int acc_w);
        longint unsigned num;
        num = (baud * os) << acc_w;
        return (num + (clk_freq / 2)) / clk_freq;
    endfunction

    function automatic logic vote3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_tick_gen.sv
// Free-running phase accumulator producing the oversampling tick.
// The tick is the accumulator carry, registered, so it is one clk wide.
module uart_rx_tick_gen
    import uart_pkg::*;
#(
    parameter int               ACC_W = 20,
    parameter logic [ACC_W-1:0] INC   = 1
) (
    input  logic clk,
    input  logic rst,
    output logic tick_o
);

    logic [ACC_W-1:0] acc_q;
    logic             tick_q;
    logic [ACC_W:0]   sum_d;

    assign sum_d  = {1'b0, acc_q} + {1'b0, INC};
    assign tick_o = tick_q;

    // Accumulate the increment every clock; the carry out becomes the tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            acc_q  <= sum_d[ACC_W-1:0];
            tick_q <= sum_d[ACC_W];
        end
    end

endmodule

// File: rtl/uart_rx_oversampled.sv
// 8N1 UART receiver with OVERSAMPLE x BAUD sampling, 3-sample majority
// vote around mid-bit, false-start rejection, break handling and a
// single-entry valid/ready output holding register.
module uart_rx_oversampled
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 25000000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 8          // even, >= 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    input  logic       rx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_overrun,
    output logic       frame_err,
    output logic       rx_busy
);

    localparam int                ACC_W = calc_acc_w(64'(CLK_FREQ), 64'(BAUD));
    localparam longint unsigned   INC_L = calc_inc(64'(CLK_FREQ), 64'(BAUD),
                                                   64'(OVERSAMPLE), ACC_W);
    localparam logic [ACC_W-1:0]  INC   = INC_L[ACC_W-1:0];

    localparam int                SC_W    = $clog2(OVERSAMPLE);
    localparam logic [SC_W-1:0]   SC_V0   = SC_W'(OVERSAMPLE / 2 - 1);
    localparam logic [SC_W-1:0]   SC_V1   = SC_W'(OVERSAMPLE / 2);
    localparam logic [SC_W-1:0]   SC_VOTE = SC_W'(OVERSAMPLE / 2 + 1);
    localparam logic [SC_W-1:0]   SC_LAST = SC_W'(OVERSAMPLE - 1);

    // Handshake: rx_valid means rx_data holds an unconsumed byte; a transfer
    // happens on any clk where rx_valid & rx_ready are both high, and
    // rx_valid drops on the next clk unless a new byte lands in that same clk.

    logic            tick;
    logic [1:0]      sync_q;
    logic            rxd_s;
    rx_state_t       state_q;
    logic [SC_W-1:0] sc_q;        // index of the sample the next tick takes
    logic [2:0]      bit_idx_q;
    logic [1:0]      vote_q;
    logic [7:0]      shreg_q;
    logic            frame_err_q;
    logic [7:0]      rx_data_q;
    logic            rx_valid_q;
    logic            rx_overrun_q;

    logic            at_v0;
    logic            at_v1;
    logic            at_vote;
    logic            at_last;
    logic            voted_bit;
    logic            byte_done;

    uart_rx_tick_gen #(
        .ACC_W (ACC_W),
        .INC   (INC)
    ) u_tick_gen (
        .clk    (clk),
        .rst    (rst),
        .tick_o (tick)
    );

    // Two-flop synchronizer for the asynchronous line, preset to idle-high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], rxd};
        end
    end

    assign rxd_s     = sync_q[1];
    assign at_v0     = (sc_q == SC_V0);
    assign at_v1     = (sc_q == SC_V1);
    assign at_vote   = (sc_q == SC_VOTE);
    assign at_last   = (sc_q == SC_LAST);
    assign voted_bit = vote3(vote_q[0], vote_q[1], rxd_s);
    assign byte_done = tick & (state_q == STOP) & at_vote & voted_bit;

    // Receive FSM with sample counter, vote capture and data shift register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            sc_q        <= '0;
            bit_idx_q   <= '0;
            vote_q      <= '0;
            shreg_q     <= '0;
            frame_err_q <= 1'b0;
        end else begin
            frame_err_q <= 1'b0;
            if (tick) begin
                if ((state_q != IDLE) && (state_q != BREAK)) begin
                    sc_q <= at_last ? '0 : sc_q + SC_W'(1);
                    if (at_v0) vote_q[0] <= rxd_s;
                    if (at_v1) vote_q[1] <= rxd_s;
                end
                case (state_q)
                    IDLE: begin
                        // The tick that sees the low line is sample 0.
                        if (!rxd_s) begin
                            state_q <= START;
                            sc_q    <= SC_W'(1);
                        end
                    end
                    START: begin
                        if (at_vote && voted_bit) begin
                            state_q <= IDLE;
                        end else if (at_last) begin
                            state_q   <= DATA;
                            bit_idx_q <= '0;
                        end
                    end
                    DATA: begin
                        if (at_vote) begin
                            shreg_q <= {voted_bit, shreg_q[7:1]};
                        end
                        if (at_last) begin
                            if (bit_idx_q == 3'd7) begin
                                state_q <= STOP;
                            end else begin
                                bit_idx_q <= bit_idx_q + 3'd1;
                            end
                        end
                    end
                    STOP: begin
                        // Leave at the vote so a following start edge half a
                        // bit early is still caught.
                        if (at_vote) begin
                            if (voted_bit) begin
                                state_q <= IDLE;
                            end else begin
                                frame_err_q <= 1'b1;
                                state_q     <= BREAK;
                            end
                        end
                    end
                    BREAK: begin
                        if (rxd_s) begin
                            state_q <= IDLE;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    // Output holding register: load on a good stop, flag overwrites.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            rx_overrun_q <= 1'b0;
        end else begin
            if (byte_done) begin
                rx_data_q    <= shreg_q;
                rx_valid_q   <= 1'b1;
                rx_overrun_q <= rx_valid_q & ~rx_ready;
            end else begin
                rx_overrun_q <= 1'b0;
                if (rx_valid_q && rx_ready) begin
                    rx_valid_q <= 1'b0;
                end
            end
        end
    end

    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign rx_overrun = rx_overrun_q;
    assign frame_err  = frame_err_q;
    assign rx_busy    = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_oversampled.sv
`timescale 1ns/1ps
module tb_uart_rx_oversampled;

    localparam int CLK_FREQ = 25000000;
    localparam int BAUD     = 250000;
    localparam int OS       = 8;
    localparam int BIT_CLK  = CLK_FREQ / BAUD;   // clk per nominal bit
    localparam int TICK_CLK = BIT_CLK / OS;
    localparam int FAST_CLK = 98;                // sender about 2% fast
    localparam int SLOW_CLK = 102;               // sender about 2% slow

    // clock / reset
    logic       clk = 1'b0;
    logic       rst;
    logic       rxd;
    logic       rx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_overrun;
    logic       frame_err;
    logic       rx_busy;

    always #20 clk = ~clk;

    uart_rx_oversampled #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD       (BAUD),
        .OVERSAMPLE (OS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rxd        (rxd),
        .rx_ready   (rx_ready),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_overrun (rx_overrun),
        .frame_err  (frame_err),
        .rx_busy    (rx_busy)
    );

    // scoreboard state
    int         total = 0;
    int         bad   = 0;
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    int         rd_idx   = 0;
    int         exp_ovr  = 0;
    int         exp_ferr = 0;
    int         ovr_cnt  = 0;
    int         ferr_cnt = 0;
    bit         model_held = 1'b0;
    logic [7:0] model_byte = '0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Observe the DUT away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (rx_overrun) ovr_cnt++;
            if (frame_err) ferr_cnt++;
            if (rx_valid && rx_ready) got_q.push_back(rx_data);
        end
    end

    // Reference model of the holding register: what the consumer should see.
    task automatic model_deliver(input logic [7:0] b);
        if (rx_ready) begin
            exp_q.push_back(b);
        end else if (model_held) begin
            exp_ovr++;
            model_byte = b;
        end else begin
            model_held = 1'b1;
            model_byte = b;
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input int bit_clk, input logic stop_bit);
        logic [9:0] bits;
        bits = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rxd = bits[i];
            wait_clks(bit_clk);
        end
        rxd = 1'b1;
    endtask

    task automatic idle_bits(input int n);
        rxd = 1'b1;
        wait_clks(n * BIT_CLK);
    endtask

    task automatic wait_valid(input string tag, input int budget);
        int n;
        n = 0;
        while (!rx_valid && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_eq({tag, "_valid"}, 32'(rx_valid), 32'd1);
    endtask

    task automatic release_held();
        rx_ready = 1'b1;
        if (model_held) begin
            exp_q.push_back(model_byte);
            model_held = 1'b0;
        end
    endtask

    task automatic compare_received(input string tag);
        check_eq({tag, "_count"}, 32'(got_q.size() - rd_idx), 32'(exp_q.size()));
        while (rd_idx < got_q.size() && exp_q.size() > 0) begin
            check_eq({tag, "_byte"}, 32'(got_q[rd_idx]), 32'(exp_q.pop_front()));
            rd_idx++;
        end
        rd_idx = got_q.size();
        exp_q.delete();
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_data"},    32'(rx_data),    32'd0);
        check_eq({tag, "_valid"},   32'(rx_valid),   32'd0);
        check_eq({tag, "_overrun"}, 32'(rx_overrun), 32'd0);
        check_eq({tag, "_ferr"},    32'(frame_err),  32'd0);
        check_eq({tag, "_busy"},    32'(rx_busy),    32'd0);
    endtask

    initial begin
        #(90000 * 40);
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        logic [7:0] skew_bytes[4];
        logic [7:0] b;
        int         bc;
        int         pick;

        skew_bytes = '{8'h00, 8'hFF, 8'h55, 8'hAA};

        // reset
        rst = 1'b1;
        rxd = 1'b1;
        rx_ready = 1'b0;
        wait_clks(5);
        @(negedge clk);
        check_idle_outputs("reset");
        wait_clks(1);
        rst = 1'b0;
        idle_bits(2);

        // exact frame, held until consumed
        send_frame(8'hA5, BIT_CLK, 1'b1);
        model_deliver(8'hA5);
        wait_valid("a5", 2 * BIT_CLK);
        check_eq("a5_data", 32'(rx_data), 32'(model_byte));
        wait_clks(3 * BIT_CLK);
        @(negedge clk);
        check_eq("a5_held", 32'(rx_valid), 32'd1);
        wait_clks(1);
        release_held();
        wait_clks(1);
        @(negedge clk);
        check_eq("a5_valid_drop", 32'(rx_valid), 32'd0);
        check_eq("a5_ferr", 32'(ferr_cnt), 32'(exp_ferr));
        check_eq("a5_ovr", 32'(ovr_cnt), 32'(exp_ovr));
        wait_clks(1);
        compare_received("a5");

        // glitch: two ticks low then high
        rxd = 1'b0;
        wait_clks(2 * TICK_CLK + 1);
        check_eq("glitch_busy_hi", 32'(rx_busy), 32'd1);
        rxd = 1'b1;
        wait_clks(BIT_CLK - (2 * TICK_CLK + 1));
        check_eq("glitch_busy_lo", 32'(rx_busy), 32'd0);
        idle_bits(1);
        check_eq("glitch_valid", 32'(rx_valid), 32'd0);
        compare_received("glitch");

        // bad stop bit, then recovery
        send_frame(8'h3C, BIT_CLK, 1'b0);
        exp_ferr++;
        idle_bits(2);
        @(negedge clk);
        check_eq("badstop_valid", 32'(rx_valid), 32'd0);
        check_eq("badstop_ferr", 32'(ferr_cnt), 32'(exp_ferr));
        wait_clks(1);
        send_frame(8'h81, BIT_CLK, 1'b1);
        model_deliver(8'h81);
        idle_bits(1);
        compare_received("badstop");

        // overrun with consumer stalled
        rx_ready = 1'b0;
        send_frame(8'h11, BIT_CLK, 1'b1);
        model_deliver(8'h11);
        send_frame(8'h22, BIT_CLK, 1'b1);
        model_deliver(8'h22);
        wait_valid("ovr", 2 * BIT_CLK);
        check_eq("ovr_data", 32'(rx_data), 32'(model_byte));
        check_eq("ovr_count", 32'(ovr_cnt), 32'(exp_ovr));
        wait_clks(1);
        release_held();
        send_frame(8'h33, BIT_CLK, 1'b1);
        model_deliver(8'h33);
        send_frame(8'h44, BIT_CLK, 1'b1);
        model_deliver(8'h44);
        idle_bits(1);
        check_eq("noovr_count", 32'(ovr_cnt), 32'(exp_ovr));
        compare_received("ovr");

        // baud skew, back-to-back
        for (int s = 0; s < 2; s++) begin
            bc = (s == 0) ? FAST_CLK : SLOW_CLK;
            for (int i = 0; i < 4; i++) begin
                send_frame(skew_bytes[i], bc, 1'b1);
                model_deliver(skew_bytes[i]);
            end
            idle_bits(1);
        end
        check_eq("skew_ferr", 32'(ferr_cnt), 32'(exp_ferr));
        compare_received("skew");

        // reset in the middle of data bit 4 with a byte already held
        rx_ready = 1'b0;
        send_frame(8'h77, BIT_CLK, 1'b1);
        model_deliver(8'h77);
        rxd = 1'b0;
        wait_clks(BIT_CLK);
        b = 8'hC3;
        for (int i = 0; i < 4; i++) begin
            rxd = b[i];
            wait_clks(BIT_CLK);
        end
        rxd = b[4];
        wait_clks(BIT_CLK / 2);
        check_eq("rstmid_busy", 32'(rx_busy), 32'd1);
        rst = 1'b1;
        model_held = 1'b0;
        wait_clks(2);
        @(negedge clk);
        check_idle_outputs("rstmid");
        rxd = 1'b1;
        wait_clks(1);
        rst = 1'b0;
        idle_bits(3);
        rx_ready = 1'b1;
        send_frame(8'h5A, BIT_CLK, 1'b1);
        model_deliver(8'h5A);
        idle_bits(1);
        compare_received("rstmid");

        // random bytes, rates and gaps
        for (int i = 0; i < 12; i++) begin
            b = 8'($urandom_range(0, 255));
            pick = $urandom_range(0, 2);
            bc = (pick == 0) ? FAST_CLK : ((pick == 1) ? BIT_CLK : SLOW_CLK);
            send_frame(b, bc, 1'b1);
            model_deliver(b);
            wait_clks(1 + $urandom_range(0, 2) * BIT_CLK);
        end
        idle_bits(1);
        check_eq("rand_ferr", 32'(ferr_cnt), 32'(exp_ferr));
        check_eq("rand_ovr", 32'(ovr_cnt), 32'(exp_ovr));
        compare_received("rand");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
